// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding, UART data
// field layout and counter width helpers.
package uart_tx_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RELEASE   = 3'd4
    } state_t;

    localparam int UART_WDATA_W  = 32;
    localparam int UART_BYTE_W   = 8;
    localparam int UART_BYTE_LSB = 0;

    // Width of an index selecting one of n items (never narrower than 1 bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must be able to hold max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly after
// i_pointer, wrapping, so the previous owner has the lowest priority.
module rr_arbiter
    import uart_tx_scheduler_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_pointer,
    output logic [N-1:0]  o_grant_onehot,
    output logic [IW-1:0] o_index
);

    // Walk from the farthest candidate to the nearest; the nearest match overwrites.
    always_comb begin
        o_grant_onehot = '0;
        o_index        = '0;
        for (int off = N; off >= 1; off--) begin
            if (i_req[(int'(i_pointer) + off) % N]) begin
                o_grant_onehot = '0;
                o_grant_onehot[(int'(i_pointer) + off) % N] = 1'b1;
                o_index = IW'((int'(i_pointer) + off) % N);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among N_REQ byte sources: round-robin grant,
// enable/ready handshake with the UART, post-byte release hold and busy timeout.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int CLOCK_RATE     = 50000000,
    parameter int BAUD_RATE      = 9600,
    parameter int RELEASE_CYCLES = CLOCK_RATE / BAUD_RATE + 2,
    parameter int TIMEOUT_CYCLES = 4 * CLOCK_RATE / BAUD_RATE
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ-1:0]   i_lock,
    input  logic [8*N_REQ-1:0] i_data,
    output logic [N_REQ-1:0]   o_ack,
    output logic [N_REQ-1:0]   o_grant,
    output logic               o_error,
    output logic               o_uart_enable,
    output logic               o_uart_rw,
    output logic [31:0]        o_uart_wdata,
    input  logic               i_uart_ready
);

    localparam int IW   = idx_width(N_REQ);
    localparam int TMAX = (TIMEOUT_CYCLES > RELEASE_CYCLES) ? TIMEOUT_CYCLES : RELEASE_CYCLES;
    localparam int TW   = cnt_width(TMAX);

    state_t                 state_q, state_d;
    logic                   rdy_meta_q, rdy_s_q;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [UART_BYTE_W-1:0] byte_q, byte_d;
    logic [UART_BYTE_W-1:0] wbyte_q, wbyte_d;
    logic [N_REQ-1:0]       grant_q, grant_d;
    logic [N_REQ-1:0]       ack_q, ack_d;
    logic                   err_q, err_d;
    logic                   en_q, en_d;
    logic                   rw_q, rw_d;
    logic [TW-1:0]          timer_q, timer_d;

    logic [UART_BYTE_W-1:0] req_byte [N_REQ];
    logic [N_REQ-1:0]       arb_onehot;
    logic [IW-1:0]          arb_index;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign req_byte[gi] = i_data[8*gi +: 8];
    end

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_arb (
        .i_req          (i_req),
        .i_pointer      (ptr_q),
        .o_grant_onehot (arb_onehot),
        .o_index        (arb_index)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        wbyte_d = wbyte_q;
        grant_d = grant_q;
        ack_d   = '0;
        err_d   = err_q;
        en_d    = en_q;
        rw_d    = rw_q;
        timer_d = timer_q;

        case (state_q)
            ST_IDLE: begin
                if (|i_req) begin
                    grant_d = arb_onehot;
                    idx_d   = arb_index;
                    byte_d  = req_byte[arb_index];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                en_d    = 1'b1;
                rw_d    = 1'b1;
                wbyte_d = byte_q;
                timer_d = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!rdy_s_q) begin
                    ack_d   = grant_q;
                    state_d = ST_WAIT_DONE;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // UART never took the byte: abandon it without acknowledging.
                    err_d   = 1'b1;
                    en_d    = 1'b0;
                    rw_d    = 1'b0;
                    wbyte_d = '0;
                    timer_d = '0;
                    state_d = ST_RELEASE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (rdy_s_q) begin
                    en_d    = 1'b0;
                    rw_d    = 1'b0;
                    wbyte_d = '0;
                    timer_d = '0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (timer_q == TW'(RELEASE_CYCLES - 1)) begin
                    timer_d = '0;
                    if (i_lock[idx_q] && i_req[idx_q]) begin
                        byte_d  = req_byte[idx_q];
                        state_d = ST_ISSUE;
                    end else begin
                        ptr_d   = idx_q;
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The synchroniser idles high so a fresh reset never looks like a busy UART.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            rdy_meta_q <= 1'b1;
            rdy_s_q    <= 1'b1;
            ptr_q      <= IW'(N_REQ - 1);
            idx_q      <= '0;
            byte_q     <= '0;
            wbyte_q    <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            en_q       <= 1'b0;
            rw_q       <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            rdy_meta_q <= i_uart_ready;
            rdy_s_q    <= rdy_meta_q;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            byte_q     <= byte_d;
            wbyte_q    <= wbyte_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            en_q       <= en_d;
            rw_q       <= rw_d;
            timer_q    <= timer_d;
        end
    end

    assign o_ack         = ack_q;
    assign o_grant       = grant_q;
    assign o_error       = err_q;
    assign o_uart_enable = en_q;
    assign o_uart_rw     = rw_q;
    assign o_uart_wdata  = {{(UART_WDATA_W - UART_BYTE_W){1'b0}}, wbyte_q};

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed vector table, hand-written
// corner sequences and randomized bursts compared against a transaction-level model.
module tb_uart_tx_scheduler;

    localparam int N       = 2;
    localparam int CLK_HZ  = 1000;
    localparam int BAUD    = 100;
    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int REL     = BIT_CYC + 2;
    localparam int TMO     = 4 * BIT_CYC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  lock = '0;
    logic [15:0]   data = '0;
    logic [N-1:0]  ack, grant;
    logic          err, en, rw;
    logic [31:0]   wdata;
    logic          rdy = 1'b1;

    int checks = 0;
    int errors = 0;

    uart_tx_scheduler #(
        .N_REQ      (N),
        .CLOCK_RATE (CLK_HZ),
        .BAUD_RATE  (BAUD)
    ) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_req         (req),
        .i_lock        (lock),
        .i_data        (data),
        .o_ack         (ack),
        .o_grant       (grant),
        .o_error       (err),
        .o_uart_enable (en),
        .o_uart_rw     (rw),
        .o_uart_wdata  (wdata),
        .i_uart_ready  (rdy)
    );

    always #5 clk = ~clk;

    // UART model: ready falls 2 cycles after it accepts enable, rises 10 bit-times later.
    bit          uart_dead = 1'b0;
    bit          um_busy = 1'b0;
    bit          um_armed = 1'b1;
    int          um_t = 0;
    logic [7:0]  um_bytes[$];

    always @(negedge clk) begin
        if (um_busy) begin
            um_t++;
            if (um_t == 2) rdy = 1'b0;
            if (um_t == 2 + 10 * BIT_CYC) begin
                rdy = 1'b1;
                um_busy = 1'b0;
            end
        end else if (en && um_armed && !uart_dead) begin
            um_busy = 1'b1;
            um_t = 0;
            um_armed = 1'b0;
            um_bytes.push_back(wdata[7:0]);
        end
        if (!en) um_armed = 1'b1;
    end

    typedef struct {
        int         owner;
        logic [7:0] b;
    } xact_t;

    xact_t      exp_q[$];
    xact_t      got_q[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         mptr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("ack_onehot0", 32'($onehot0(ack)), 32'd1);
        check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        check("ack_within_grant", 32'(ack & ~grant), 32'd0);
        if (en) check("wdata_upper_zero", {8'h00, wdata[31:8]}, 32'd0);
    endtask

    task automatic drive();
        req = {q1.size() != 0, q0.size() != 0};
        data[7:0]  = (q0.size() != 0) ? q0[0] : 8'h00;
        data[15:8] = (q1.size() != 0) ? q1[0] : 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        lock = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Serve the queues until they are empty and the scheduler is idle again.
    task automatic service(input int budget);
        int n;
        n = 0;
        drive();
        while ((q0.size() != 0 || q1.size() != 0 || grant != 0) && n < budget) begin
            step();
            n++;
            if (ack != 0) begin
                xact_t x;
                x.owner = ack[1] ? 1 : 0;
                x.b = (um_bytes.size() != 0) ? um_bytes.pop_front() : 8'h00;
                got_q.push_back(x);
                if (x.owner == 0 && q0.size() != 0) void'(q0.pop_front());
                if (x.owner == 1 && q1.size() != 0) void'(q1.pop_front());
            end
            drive();
        end
        check("service_in_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic compare_order(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_owner"}, 32'(got_q[i].owner), 32'(exp_q[i].owner));
            check({tag, "_byte"}, {24'h0, got_q[i].b}, {24'h0, exp_q[i].b});
        end
    endtask

    // Reference: whole-message view. Owner = first pending requester after the
    // last owner; a locked owner empties its whole queue before moving on.
    function automatic void predict(input logic [7:0] a0[$], input logic [7:0] a1[$],
                                    input logic [1:0] lk);
        int cnt[2];
        int pos[2];
        int k;
        bit more;
        cnt[0] = a0.size();
        cnt[1] = a1.size();
        pos[0] = 0;
        pos[1] = 0;
        while ((cnt[0] - pos[0]) + (cnt[1] - pos[1]) > 0) begin
            k = -1;
            for (int off = 2; off >= 1; off--) begin
                if (pos[(mptr + off) % 2] < cnt[(mptr + off) % 2]) k = (mptr + off) % 2;
            end
            more = 1'b1;
            while (more) begin
                exp_q.push_back('{k, (k == 0) ? a0[pos[0]] : a1[pos[1]]});
                pos[k]++;
                more = lk[k] && (pos[k] < cnt[k]);
            end
            mptr = k;
        end
    endfunction

    typedef struct {
        logic [1:0] req;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] exp_ack;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   acks;
        bit   saw;
        logic [7:0] b;
        logic [1:0] lk;

        // Single-byte vectors from reset (pointer starts at requester 1).
        vecs[0] = '{2'b01, 8'h41, 8'h00, 2'b01, 8'h41};
        vecs[1] = '{2'b11, 8'h12, 8'h34, 2'b10, 8'h34};
        vecs[2] = '{2'b11, 8'h56, 8'h78, 2'b01, 8'h56};
        vecs[3] = '{2'b10, 8'h00, 8'h9A, 2'b10, 8'h9A};
        vecs[4] = '{2'b10, 8'h00, 8'hBC, 2'b10, 8'hBC};
        vecs[5] = '{2'b11, 8'hDE, 8'hF0, 2'b01, 8'hDE};
        vecs[6] = '{2'b01, 8'h5A, 8'h00, 2'b01, 8'h5A};
        vecs[7] = '{2'b11, 8'h11, 8'h22, 2'b10, 8'h22};

        do_reset();
        check("rst_enable", 32'(en), 32'd0);
        check("rst_rw", 32'(rw), 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_error", 32'(err), 32'd0);

        for (int i = 0; i < 8; i++) begin
            um_bytes.delete();
            req  = vecs[i].req;
            data = {vecs[i].d1, vecs[i].d0};
            step();
            check("vec_grant_latency", 32'(grant), 32'(vecs[i].exp_ack));
            check("vec_enable_not_yet", 32'(en), 32'd0);
            step();
            check("vec_enable", 32'(en), 32'd1);
            check("vec_rw", 32'(rw), 32'd1);
            check("vec_wdata", wdata, {24'h0, vecs[i].exp_byte});
            req = '0;  // withdrawn during WAIT_BUSY: byte must still go out
            acks = 0;
            n = 0;
            while (en && n < 300) begin
                step();
                n++;
                if (ack != 0) begin
                    acks++;
                    check("vec_ack_owner", 32'(ack), 32'(vecs[i].exp_ack));
                end
            end
            n = 0;
            while (grant != 0 && n < REL + 10) begin
                step();
                n++;
                if (ack != 0) acks++;
            end
            check("vec_release_cycles", 32'(n), 32'(REL));
            check("vec_ack_count", 32'(acks), 32'd1);
            b = (um_bytes.size() != 0) ? um_bytes.pop_front() : 8'h00;
            check("vec_uart_byte", {24'h0, b}, {24'h0, vecs[i].exp_byte});
            step();
        end

        // Both requesters with four bytes each from reset: strict alternation from req0.
        do_reset();
        mptr = 1;
        exp_q.delete();
        got_q.delete();
        um_bytes.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(8'hA0 + 8'(i));
            q1.push_back(8'hB0 + 8'(i));
        end
        predict(q0, q1, 2'b00);
        service(3000);
        compare_order("alternate");
        for (int i = 0; i < got_q.size(); i++)
            check("alternate_pattern", 32'(got_q[i].owner), 32'(i % 2));

        // Locked three-byte message from req1 while req0 waits.
        exp_q.delete();
        got_q.delete();
        um_bytes.delete();
        lock = 2'b10;
        q1.push_back(8'hC1);
        q1.push_back(8'hC2);
        q1.push_back(8'hC3);
        drive();
        step();
        check("lock_first_grant", 32'(grant), 32'h2);
        q0.push_back(8'hD0);
        exp_q.push_back('{1, 8'hC1});
        exp_q.push_back('{1, 8'hC2});
        exp_q.push_back('{1, 8'hC3});
        exp_q.push_back('{0, 8'hD0});
        service(2000);
        compare_order("locked");
        lock = 2'b00;

        // UART that never leaves ready: timeout, sticky error, then recovery.
        check("tmo_error_before", 32'(err), 32'd0);
        uart_dead = 1'b1;
        req = 2'b01;
        data = {8'h00, 8'h77};
        n = 0;
        while (!en && n < 10) begin step(); n++; end
        check("tmo_enable_rise", 32'(en), 32'd1);
        n = 0;
        saw = 1'b0;
        while (en && n < TMO + 20) begin
            step();
            n++;
            if (ack != 0) saw = 1'b1;
        end
        check("tmo_enable_cycles", 32'(n), 32'(TMO));
        check("tmo_error", 32'(err), 32'd1);
        req = '0;
        n = 0;
        while (grant != 0 && n < REL + 10) begin
            step();
            n++;
            if (ack != 0) saw = 1'b1;
        end
        check("tmo_no_ack", 32'(saw), 32'd0);
        check("tmo_release", 32'(n), 32'(REL));
        uart_dead = 1'b0;
        exp_q.delete();
        got_q.delete();
        um_bytes.delete();
        q0.push_back(8'h99);
        exp_q.push_back('{0, 8'h99});
        service(400);
        compare_order("after_tmo");
        check("tmo_error_sticky", 32'(err), 32'd1);

        // Reset while the UART is still shifting the byte out.
        req = 2'b10;
        data = {8'hC3, 8'h00};
        n = 0;
        while (ack == 0 && n < 100) begin step(); n++; end
        check("rstmid_ack", 32'(ack), 32'h2);
        req = '0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        check("rstmid_enable", 32'(en), 32'd0);
        check("rstmid_rw", 32'(rw), 32'd0);
        check("rstmid_wdata", wdata, 32'd0);
        check("rstmid_grant", 32'(grant), 32'd0);
        check("rstmid_ack_zero", 32'(ack), 32'd0);
        check("rstmid_error_cleared", 32'(err), 32'd0);
        rst_n = 1'b1;
        n = 0;
        while (um_busy && n < 300) begin step(); n++; end
        check("rstmid_uart_idle", 32'(um_busy), 32'd0);
        exp_q.delete();
        got_q.delete();
        um_bytes.delete();
        q1.push_back(8'h3C);
        exp_q.push_back('{1, 8'h3C});
        service(400);
        compare_order("after_rst");

        // Randomized message mixes against the reference model.
        do_reset();
        mptr = 1;
        for (int r = 0; r < 10; r++) begin
            exp_q.delete();
            got_q.delete();
            um_bytes.delete();
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) q0.push_back(8'($urandom));
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) q1.push_back(8'($urandom));
            lk = 2'($urandom_range(0, 3));
            lock = lk;
            predict(q0, q1, lk);
            service(4000);
            compare_order("random");
            lock = '0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
